// File: rtl/gsplat_pkg.sv
// -----------------------------------------------------------------------------
// gsplat_pkg
//   Shared definitions for the gsplat frame-level tile scheduler.
//   - HDR_QWORDS / SPLAT_QWORDS : descriptor geometry in DDR3 qwords
//   - tile_hdr_t                : decoded fields of header qword0
//   - disp_state_t              : dispatcher FSM encoding
//   - next_desc_addr()          : address of the descriptor after this one
// -----------------------------------------------------------------------------
package gsplat_pkg;

    localparam int HDR_QWORDS   = 2;
    localparam int SPLAT_QWORDS = 4;

    // Packed so that header qword0[47:0] casts straight onto it (px in the LSBs).
    typedef struct packed {
        logic [15:0] count;
        logic [15:0] py;
        logic [15:0] px;
    } tile_hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_REQ,
        ST_HDR_BEAT0,
        ST_HDR_BEAT1,
        ST_DISPATCH,
        ST_DRAIN,
        ST_DONE
    } disp_state_t;

    // Computed at 32 bits; callers truncate to their address width, which is
    // equivalent to wrapping modulo 2^ADDR_W for any ADDR_W <= 32.
    function automatic logic [31:0] next_desc_addr(input logic [31:0] cur,
                                                   input logic [15:0] count);
        return cur + 32'(HDR_QWORDS) + (32'(count) << 2);
    endfunction

endpackage

// File: rtl/gsplat_core_pick.sv
// -----------------------------------------------------------------------------
// gsplat_core_pick
//   Lowest-index-first priority encoder over the idle cores.
//   Ports:
//     inflight_i  in   N   per-core busy mask (1 = tile in flight)
//     grant_o     out  N   one-hot grant of the lowest idle core (0 if none)
//     valid_o     out  1   at least one core is idle
// -----------------------------------------------------------------------------
module gsplat_core_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] inflight_i,
    output logic [N-1:0] grant_o,
    output logic         valid_o
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!inflight_i[i] && !valid_o) begin
                grant_o[i] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gsplat_tile_dispatcher.sv
// -----------------------------------------------------------------------------
// gsplat_tile_dispatcher
//   Frame-level scheduler for the gsplat rasterizer cores. Walks the packed
//   tile-descriptor list in DDR3, fetches each 2-qword header over a shared
//   read port and hands the tile to the lowest-index idle core. The next
//   header is fetched while the cores work; frame_done pulses once every
//   dispatched tile has reported completion.
//   Ports:
//     clk, reset                    clock, synchronous active-high reset
//     frame_start/list_addr/
//       tile_count                  frame request (ignored while busy)
//     busy, frame_done              frame status
//     rd_addr/rd_burstcnt/rd_req/
//       rd_ack                      header read request (held until ack)
//     rd_data/rd_data_valid         read return beats
//     core_tile_start               one-hot dispatch pulse
//     core_tile_addr/px/py/
//       core_splat_count            shared tile bus, qualified by start
//     core_tile_done                per-core completion pulse
// -----------------------------------------------------------------------------
module gsplat_tile_dispatcher
    import gsplat_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 29
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [ADDR_W-1:0]    list_addr,
    input  logic [15:0]          tile_count,
    output logic                 busy,
    output logic                 frame_done,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic [7:0]           rd_burstcnt,
    output logic                 rd_req,
    input  logic                 rd_ack,
    input  logic [63:0]          rd_data,
    input  logic                 rd_data_valid,
    output logic [NUM_CORES-1:0] core_tile_start,
    output logic [ADDR_W-1:0]    core_tile_addr,
    output logic [15:0]          core_tile_px,
    output logic [15:0]          core_tile_py,
    output logic [15:0]          core_splat_count,
    input  logic [NUM_CORES-1:0] core_tile_done
);

    disp_state_t            state_q, state_d;
    logic [ADDR_W-1:0]      cur_q, cur_d;          // next descriptor to fetch
    logic [15:0]            remaining_q, remaining_d; // headers not yet fetched
    logic                   last_q, last_d;        // buffered header is the final tile
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    tile_hdr_t              hdr_q, hdr_d;          // header buffer
    logic [ADDR_W-1:0]      hdr_addr_q, hdr_addr_d;
    logic                   hdr_valid_q, hdr_valid_d;
    tile_hdr_t              bus_hdr_q, bus_hdr_d;  // last value driven on the tile bus
    logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
    logic [NUM_CORES-1:0]   inflight_q, inflight_d;

    logic [NUM_CORES-1:0]   grant;
    logic                   grant_valid;
    logic                   dispatch;
    tile_hdr_t              rd_hdr;
    tile_hdr_t              bus_hdr;
    logic                   unused_rd_hi;

    assign rd_hdr       = tile_hdr_t'(rd_data[47:0]);
    assign unused_rd_hi = ^rd_data[63:48];

    gsplat_core_pick #(
        .N (NUM_CORES)
    ) u_pick (
        .inflight_i (inflight_q),
        .grant_o    (grant),
        .valid_o    (grant_valid)
    );

    // Dispatch is combinational from registered state so the tile leaves in
    // the first DISPATCH cycle, one cycle after the second header beat.
    assign dispatch = (state_q == ST_DISPATCH) && hdr_valid_q && grant_valid;

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        remaining_d  = remaining_q;
        last_d       = last_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        hdr_d        = hdr_q;
        hdr_addr_d   = hdr_addr_q;
        hdr_valid_d  = hdr_valid_q;
        bus_hdr_d    = bus_hdr_q;
        bus_addr_d   = bus_addr_q;

        // A done pulse only clears a set bit; a dispatch only targets a clear
        // bit, so a done and a dispatch in the same cycle never conflict.
        inflight_d = (inflight_q & ~core_tile_done) | (dispatch ? grant : '0);

        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    cur_d       = list_addr;
                    remaining_d = tile_count;
                    last_d      = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = (tile_count == 16'd0) ? ST_DONE : ST_HDR_REQ;
                end
            end
            ST_HDR_REQ: begin
                if (rd_ack) begin
                    state_d = ST_HDR_BEAT0;
                end
            end
            ST_HDR_BEAT0: begin
                if (rd_data_valid) begin
                    hdr_d       = rd_hdr;
                    hdr_addr_d  = cur_q;
                    cur_d       = ADDR_W'(next_desc_addr(32'(cur_q), rd_hdr.count));
                    remaining_d = remaining_q - 16'd1;
                    state_d     = ST_HDR_BEAT1;
                end
            end
            ST_HDR_BEAT1: begin
                if (rd_data_valid) begin
                    hdr_valid_d = 1'b1;
                    last_d      = (remaining_q == 16'd0);
                    state_d     = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                if (dispatch) begin
                    hdr_valid_d = 1'b0;
                    bus_hdr_d   = hdr_q;
                    bus_addr_d  = hdr_addr_q;
                    state_d     = last_q ? ST_DRAIN : ST_HDR_REQ;
                end
            end
            ST_DRAIN: begin
                // Look at the mask with this cycle's done pulses applied so the
                // final completion is not delayed by an extra cycle.
                if (inflight_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            remaining_q  <= '0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            hdr_q        <= '0;
            hdr_addr_q   <= '0;
            hdr_valid_q  <= 1'b0;
            bus_hdr_q    <= '0;
            bus_addr_q   <= '0;
            inflight_q   <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            remaining_q  <= remaining_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            hdr_q        <= hdr_d;
            hdr_addr_q   <= hdr_addr_d;
            hdr_valid_q  <= hdr_valid_d;
            bus_hdr_q    <= bus_hdr_d;
            bus_addr_q   <= bus_addr_d;
            inflight_q   <= inflight_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // Request fields come straight from state/address registers, so they are
    // stable for as long as the request waits for rd_ack. The burst count is
    // qualified by rd_req so the port reads all-zero out of reset.
    assign rd_req      = (state_q == ST_HDR_REQ);
    assign rd_addr     = cur_q;
    assign rd_burstcnt = rd_req ? 8'(HDR_QWORDS) : 8'd0;

    // Tile bus shows the buffered header in the dispatch cycle and keeps the
    // last dispatched tile otherwise.
    assign core_tile_start  = dispatch ? grant : '0;
    assign bus_hdr          = dispatch ? hdr_q : bus_hdr_q;
    assign core_tile_addr   = dispatch ? hdr_addr_q : bus_addr_q;
    assign core_tile_px     = bus_hdr.px;
    assign core_tile_py     = bus_hdr.py;
    assign core_splat_count = bus_hdr.count;

endmodule

// File: tb/tb_gsplat_tile_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_gsplat_tile_dispatcher
//   Directed self-checking bench for gsplat_tile_dispatcher (NUM_CORES=2,
//   ADDR_W=29). Inputs change 1 ns after the rising edge and outputs are
//   sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_gsplat_tile_dispatcher;

    localparam int NUM_CORES = 2;
    localparam int ADDR_W    = 29;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 frame_start;
    logic [ADDR_W-1:0]    list_addr;
    logic [15:0]          tile_count;
    logic                 busy;
    logic                 frame_done;
    logic [ADDR_W-1:0]    rd_addr;
    logic [7:0]           rd_burstcnt;
    logic                 rd_req;
    logic                 rd_ack;
    logic [63:0]          rd_data;
    logic                 rd_data_valid;
    logic [NUM_CORES-1:0] core_tile_start;
    logic [ADDR_W-1:0]    core_tile_addr;
    logic [15:0]          core_tile_px;
    logic [15:0]          core_tile_py;
    logic [15:0]          core_splat_count;
    logic [NUM_CORES-1:0] core_tile_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    gsplat_tile_dispatcher #(
        .NUM_CORES (NUM_CORES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .frame_start      (frame_start),
        .list_addr        (list_addr),
        .tile_count       (tile_count),
        .busy             (busy),
        .frame_done       (frame_done),
        .rd_addr          (rd_addr),
        .rd_burstcnt      (rd_burstcnt),
        .rd_req           (rd_req),
        .rd_ack           (rd_ack),
        .rd_data          (rd_data),
        .rd_data_valid    (rd_data_valid),
        .core_tile_start  (core_tile_start),
        .core_tile_addr   (core_tile_addr),
        .core_tile_px     (core_tile_px),
        .core_tile_py     (core_tile_py),
        .core_splat_count (core_splat_count),
        .core_tile_done   (core_tile_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Answer one header read: wait (bounded) for rd_req, check the request,
    // hold rd_ack off for ack_delay cycles, then return qword0/qword1.
    task automatic serve(input string tag, input logic [ADDR_W-1:0] addr,
                         input logic [15:0] px, input logic [15:0] py,
                         input logic [15:0] cnt, input int ack_delay);
        int n = 0;
        while (rd_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 64'(rd_req), 64'(1));
        check({tag, "_addr"}, 64'(rd_addr), 64'(addr));
        check({tag, "_burst"}, 64'(rd_burstcnt), 64'(2));
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            check({tag, "_hold"}, 64'({rd_req, rd_burstcnt, rd_addr}),
                  64'({1'b1, 8'd2, addr}));
        end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check({tag, "_req_drop"}, 64'(rd_req), 64'(0));
        rd_data       = {16'hDEAD, cnt, py, px};
        rd_data_valid = 1'b1;
        tick();
        rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        rd_data_valid = 1'b0;
        rd_data       = '0;
    endtask

    task automatic check_dispatch(input string tag, input logic [NUM_CORES-1:0] start,
                                  input logic [ADDR_W-1:0] addr, input logic [15:0] px,
                                  input logic [15:0] py, input logic [15:0] cnt);
        check({tag, "_start"}, 64'(core_tile_start), 64'(start));
        check({tag, "_bus"}, {core_tile_addr[15:0], core_tile_px, core_tile_py, core_splat_count},
              {addr[15:0], px, py, cnt});
        check({tag, "_addr"}, 64'(core_tile_addr), 64'(addr));
    endtask

    task automatic wait_frame_done(input string tag);
        int n = 0;
        while (frame_done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(frame_done), 64'(1));
    endtask

    initial begin
        reset          = 1'b1;
        frame_start    = 1'b0;
        list_addr      = '0;
        tile_count     = '0;
        rd_ack         = 1'b0;
        rd_data        = '0;
        rd_data_valid  = 1'b0;
        core_tile_done = '0;
        tick(); tick(); tick();

        // Reset state
        check("rst_ctrl", 64'({busy, frame_done, rd_req, rd_burstcnt, core_tile_start}), 64'(0));
        check("rst_rd_addr", 64'(rd_addr), 64'(0));
        check("rst_bus", 64'({core_tile_px, core_tile_py, core_splat_count}), 64'(0));
        reset = 1'b0;
        tick();

        // 1: three tiles (counts 0/5/1), cores never done
        frame_start = 1'b1; list_addr = 29'h100; tile_count = 16'd3;
        tick();
        frame_start = 1'b0;
        check("s1_busy", 64'(busy), 64'(1));
        serve("s1_t0", 29'h100, 16'h0011, 16'h0022, 16'd0, 0);
        check_dispatch("s1_d0", 2'b01, 29'h100, 16'h0011, 16'h0022, 16'd0);
        tick();
        check("s1_start_idle", 64'(core_tile_start), 64'(0));
        check("s1_bus_hold", 64'(core_tile_px), 64'(16'h0011));
        // frame_start while busy and a stray beat in HDR_REQ must both be ignored
        frame_start = 1'b1; list_addr = 29'h500; tile_count = 16'd0;
        rd_data = 64'h1234_5678_9ABC_DEF0; rd_data_valid = 1'b1;
        tick();
        frame_start = 1'b0; rd_data = '0; rd_data_valid = 1'b0;
        serve("s1_t1", 29'h102, 16'h0033, 16'h0044, 16'd5, 0);
        check_dispatch("s1_d1", 2'b10, 29'h102, 16'h0033, 16'h0044, 16'd5);
        tick();
        serve("s1_t2", 29'h118, 16'h0055, 16'h0066, 16'd1, 0);
        check("s1_t2_wait", 64'(core_tile_start), 64'(0));
        tick(); tick(); tick();
        check("s1_t2_still_wait", 64'(core_tile_start), 64'(0));
        check("s1_bus_hold2", 64'({core_tile_px, core_splat_count}), 64'({16'h0033, 16'd5}));

        // 2: core1 done frees it for the third tile, then drain
        core_tile_done = 2'b10;
        tick();
        core_tile_done = 2'b00;
        check_dispatch("s2_d2", 2'b10, 29'h118, 16'h0055, 16'h0066, 16'd1);
        tick();
        core_tile_done = 2'b01;
        tick();
        core_tile_done = 2'b10;
        check("s2_drain_busy", 64'({busy, frame_done}), 64'(2'b10));
        tick();
        core_tile_done = 2'b00;
        check("s2_done_state", 64'({busy, frame_done}), 64'(2'b10));
        tick();
        check("s2_frame_done", 64'({busy, frame_done}), 64'(2'b01));
        tick();
        check("s2_done_pulse_end", 64'(frame_done), 64'(0));

        // 3: empty frame
        frame_start = 1'b1; list_addr = 29'h700; tile_count = 16'd0;
        tick();
        frame_start = 1'b0;
        check("s3_cyc1", 64'({busy, frame_done, rd_req}), 64'(3'b100));
        tick();
        check("s3_cyc2", 64'({busy, frame_done, rd_req}), 64'(3'b010));

        // 4 + 5: ack withheld 10 cycles; done/dispatch collision
        frame_start = 1'b1; list_addr = 29'h200; tile_count = 16'd2;
        tick();
        frame_start = 1'b0;
        serve("s4_t0", 29'h200, 16'h0001, 16'h0002, 16'd0, 10);
        check_dispatch("s4_d0", 2'b01, 29'h200, 16'h0001, 16'h0002, 16'd0);
        tick();
        serve("s5_t1", 29'h202, 16'h0003, 16'h0004, 16'd0, 0);
        core_tile_done = 2'b01;
        check_dispatch("s5_d1", 2'b10, 29'h202, 16'h0003, 16'h0004, 16'd0);
        tick();
        core_tile_done = 2'b00;
        check("s5_inflight", 64'(dut.inflight_q), 64'(2'b10));
        core_tile_done = 2'b01;
        tick();
        core_tile_done = 2'b00;
        check("s5_stray_busy_core", 64'({dut.inflight_q, frame_done}), 64'(3'b100));
        core_tile_done = 2'b10;
        tick();
        core_tile_done = 2'b00;
        wait_frame_done("s5_frame_done");
        tick();
        core_tile_done = 2'b01;
        tick();
        core_tile_done = 2'b00;
        check("s5_stray_idle", 64'({dut.inflight_q, busy, frame_done, core_tile_start}),
              64'(0));

        // 6: address wrap, then reset in HDR_BEAT0, then a clean frame
        frame_start = 1'b1; list_addr = 29'h1FFF_FFFE; tile_count = 16'd2;
        tick();
        frame_start = 1'b0;
        serve("s6_t0", 29'h1FFF_FFFE, 16'h0007, 16'h0008, 16'd0, 0);
        check_dispatch("s6_d0", 2'b01, 29'h1FFF_FFFE, 16'h0007, 16'h0008, 16'd0);
        tick();
        check("s6_wrap_addr", 64'({rd_req, rd_addr}), 64'({1'b1, 29'h0}));
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        reset  = 1'b1;
        tick();
        check("s6_rst_ctrl", 64'({busy, frame_done, rd_req, rd_burstcnt, core_tile_start}), 64'(0));
        check("s6_rst_rd_addr", 64'(rd_addr), 64'(0));
        check("s6_rst_bus", 64'({core_tile_px, core_tile_py, core_splat_count}), 64'(0));
        check("s6_rst_core_addr", 64'(core_tile_addr), 64'(0));
        reset = 1'b0;
        tick();
        frame_start = 1'b1; list_addr = 29'h300; tile_count = 16'd1;
        tick();
        frame_start = 1'b0;
        serve("s6_t1", 29'h300, 16'h0009, 16'h000A, 16'd7, 0);
        check_dispatch("s6_d1", 2'b01, 29'h300, 16'h0009, 16'h000A, 16'd7);
        tick();
        core_tile_done = 2'b01;
        tick();
        core_tile_done = 2'b00;
        wait_frame_done("s6_frame_done");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
